// File: rtl/fir_eq_filter_pkg.sv
// Shared constants, accumulator sizing and the round/saturate helper for the
// equalizer FIR datapath.
package fir_eq_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned COEF_W_DEF = 16;
  localparam int unsigned TAPS_DEF   = 16;
  localparam int unsigned OUT_W_DEF  = 17;

  // Working widths of round_sat; callers sign-extend into / truncate out of these.
  localparam int unsigned RS_VAL_W = 64;
  localparam int unsigned RS_OUT_W = 32;

  typedef struct packed {
    logic                       sat;
    logic signed [RS_OUT_W-1:0] data;
  } round_sat_t;

  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned coef_w,
                                            input int unsigned taps);
    return data_w + coef_w + int'($clog2(taps));
  endfunction

  // Round half up, shift right arithmetically by frac, clip to out_w signed bits.
  function automatic round_sat_t round_sat(input logic signed [RS_VAL_W-1:0] value,
                                           input int unsigned frac,
                                           input int unsigned out_w);
    logic signed [RS_VAL_W-1:0] half;
    logic signed [RS_VAL_W-1:0] rnd;
    logic signed [RS_VAL_W-1:0] lim;
    logic signed [RS_VAL_W-1:0] hi;
    logic signed [RS_VAL_W-1:0] lo;
    round_sat_t r;
    half = '0;
    if (frac != 0) half = RS_VAL_W'(1) << (frac - 1);
    rnd  = (value + half) >>> frac;
    lim  = RS_VAL_W'(1) << (out_w - 1);
    hi   = lim - 1;
    lo   = -lim;
    r.sat  = 1'b0;
    r.data = rnd[RS_OUT_W-1:0];
    if (rnd > hi) begin
      r.sat  = 1'b1;
      r.data = hi[RS_OUT_W-1:0];
    end else if (rnd < lo) begin
      r.sat  = 1'b1;
      r.data = lo[RS_OUT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_eq_filter_if.sv
// Sample stream, flush and coefficient-programming bundle of the FIR filter.
interface fir_eq_filter_if
  import fir_eq_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned COEF_W = COEF_W_DEF,
  parameter int unsigned TAPS   = TAPS_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF
);
  logic                      in_valid;
  logic signed [DATA_W-1:0]  in_data;
  logic                      flush;
  logic                      coef_we;
  logic [$clog2(TAPS)-1:0]   coef_addr;
  logic signed [COEF_W-1:0]  coef_wdata;
  logic                      coef_commit;
  logic                      out_valid;
  logic signed [OUT_W-1:0]   out_data;
  logic                      out_sat;

  modport master (
    output in_valid, in_data, flush, coef_we, coef_addr, coef_wdata, coef_commit,
    input  out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, flush, coef_we, coef_addr, coef_wdata, coef_commit,
    output out_valid, out_data, out_sat
  );
endinterface

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient store: writes land in the shadow bank, commit
// copies the whole shadow bank into the active bank on one edge.
module fir_coef_bank
  import fir_eq_pkg::*;
#(
  parameter int unsigned COEF_W = COEF_W_DEF,
  parameter int unsigned TAPS   = TAPS_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(TAPS)-1:0]  addr,
  input  logic signed [COEF_W-1:0] wdata,
  input  logic                     commit,
  output logic [TAPS*COEF_W-1:0]   active
);
  logic signed [COEF_W-1:0] shadow [TAPS];
  logic signed [COEF_W-1:0] act    [TAPS];

  // Same-cycle write+commit: commit reads the pre-write shadow value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        shadow[i] <= '0;
        act[i]    <= '0;
      end
    end else begin
      if (we) shadow[addr] <= wdata;
      if (commit) begin
        for (int unsigned i = 0; i < TAPS; i++) act[i] <= shadow[i];
      end
    end
  end

  always_comb begin
    active = '0;
    for (int unsigned i = 0; i < TAPS; i++) active[i*COEF_W +: COEF_W] = act[i];
  end
endmodule

// File: rtl/fir_eq_filter.sv
// Streaming equalizer FIR: gated delay line, registered products, registered
// sum, then round/saturate into the output registers (3-cycle latency).
module fir_eq_filter
  import fir_eq_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned COEF_W = COEF_W_DEF,
  parameter int unsigned TAPS   = TAPS_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF,
  parameter int unsigned FRAC   = COEF_W - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  fir_eq_filter_if.slave   bus
);
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = acc_width(DATA_W, COEF_W, TAPS);

  logic [TAPS*COEF_W-1:0]   coef_flat;
  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [DATA_W-1:0] taps [TAPS];
  logic signed [PROD_W-1:0] prod [TAPS];
  logic signed [ACC_W-1:0]  sum_c;
  logic signed [ACC_W-1:0]  acc;
  logic [2:0]               vld;
  logic                     accept;
  round_sat_t               rs;
  logic                     out_valid_q;
  logic                     out_sat_q;
  logic signed [OUT_W-1:0]  out_data_q;
  logic                     unused_rs;

  fir_coef_bank #(
    .COEF_W (COEF_W),
    .TAPS   (TAPS)
  ) u_coef_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (bus.coef_we),
    .addr   (bus.coef_addr),
    .wdata  (bus.coef_wdata),
    .commit (bus.coef_commit),
    .active (coef_flat)
  );

  assign accept = bus.in_valid & ~bus.flush;

  always_comb begin
    for (int unsigned i = 0; i < TAPS; i++) coef[i] = coef_flat[i*COEF_W +: COEF_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TAPS; i++) taps[i] <= '0;
    end else if (bus.flush) begin
      for (int unsigned i = 0; i < TAPS; i++) taps[i] <= '0;
    end else if (bus.in_valid) begin
      taps[0] <= bus.in_data;
      for (int unsigned i = 1; i < TAPS; i++) taps[i] <= taps[i-1];
    end
  end

  // Products sample the active bank one edge after accept, so a commit on the
  // accept edge itself already applies to that sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TAPS; i++) prod[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < TAPS; i++) prod[i] <= PROD_W'(taps[i]) * PROD_W'(coef[i]);
    end
  end

  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < TAPS; i++) sum_c = sum_c + ACC_W'(prod[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '0;
    else        acc <= sum_c;
  end

  always_comb rs = round_sat(RS_VAL_W'(acc), FRAC, OUT_W);
  assign unused_rs = ^rs.data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld         <= '0;
      out_valid_q <= 1'b0;
    end else if (bus.flush) begin
      vld         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      vld         <= {vld[1:0], accept};
      out_valid_q <= vld[2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else if (vld[2] && !bus.flush) begin
      out_data_q <= rs.data[OUT_W-1:0];
      out_sat_q  <= rs.sat;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_fir_eq_filter.sv
// Directed bench for fir_eq_filter with hand-computed expected outputs.
module tb_fir_eq_filter;
  import fir_eq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fir_eq_filter_if #(.DATA_W(16), .COEF_W(16), .TAPS(16), .OUT_W(17)) bus ();

  fir_eq_filter #(
    .DATA_W (16),
    .COEF_W (16),
    .TAPS   (16),
    .OUT_W  (17)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int cyc = 0;
  int acc_cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int q_data[$];
  int q_sat[$];
  int q_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      q_data.push_back(int'(bus.out_data));
      q_sat.push_back(int'(bus.out_sat));
      q_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int d, input logic we, input int a,
                       input int wd, input logic cm, input logic fl);
    bus.in_valid    = v;
    bus.in_data     = 16'(d);
    bus.coef_we     = we;
    bus.coef_addr   = 4'(a);
    bus.coef_wdata  = 16'(wd);
    bus.coef_commit = cm;
    bus.flush       = fl;
    @(posedge clk);
    #1;
    if (v && !fl) acc_cyc = cyc;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.coef_we     = 1'b0;
    bus.coef_addr   = '0;
    bus.coef_wdata  = '0;
    bus.coef_commit = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic send(input int d);            drive(1'b1, d, 1'b0, 0, 0, 1'b0, 1'b0); endtask
  task automatic wr(input int a, input int v); drive(1'b0, 0, 1'b1, a, v, 1'b0, 1'b0); endtask
  task automatic commit();                     drive(1'b0, 0, 1'b0, 0, 0, 1'b1, 1'b0); endtask
  task automatic flush_pl();                   drive(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b1); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask
  task automatic clear_q();
    q_data.delete();
    q_sat.delete();
    q_cyc.delete();
  endtask
  task automatic load_bank(input int c [16]);
    for (int i = 0; i < 16; i++) wr(i, c[i]);
    commit();
  endtask

  int c_imp [16];
  int c_rnd [16];
  int c_max [16];
  int seq   [20] = '{100, -200, 3000, -4000, 32767, -32768, 5, 0, 12345, -12345,
                     777, -1, 2, 30000, -30000, 1, -7, 8000, -8000, 42};
  int ref_a [$];
  int exp_cu [7] = '{500, 500, 500, 250, 250, 250, 125};
  int a0;

  initial begin
    for (int i = 0; i < 16; i++) begin
      c_imp[i] = 1000 * (i + 1);
      c_rnd[i] = (i == 0) ? 16384 : 0;
      c_max[i] = 32767;
    end
    bus.in_valid = 1'b0; bus.in_data = '0; bus.flush = 1'b0; bus.coef_we = 1'b0;
    bus.coef_addr = '0; bus.coef_wdata = '0; bus.coef_commit = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", bus.out_valid, 0);
    check("reset_data", bus.out_data, 0);
    check("reset_sat", bus.out_sat, 0);
    rst_n = 1'b1;
    idle(1);

    // impulse response and latency
    load_bank(c_imp);
    clear_q();
    send(32767);
    a0 = acc_cyc;
    repeat (15) send(0);
    idle(6);
    check("imp_count", q_data.size(), 16);
    if (q_cyc.size() > 0) check("imp_latency", q_cyc[0] - a0, 3);
    for (int j = 0; j < q_data.size() && j < 16; j++)
      check($sformatf("imp_%0d", j), q_data[j], 1000 * (j + 1));

    // rounding
    flush_pl();
    load_bank(c_rnd);
    clear_q();
    send(32767);
    send(-32767);
    idle(6);
    check("rnd_count", q_data.size(), 2);
    if (q_data.size() >= 2) begin
      check("rnd_pos", q_data[0], 16384);
      check("rnd_pos_sat", q_sat[0], 0);
      check("rnd_neg", q_data[1], -16383);
    end

    // saturation, positive then negative
    flush_pl();
    load_bank(c_max);
    clear_q();
    repeat (16) send(32767);
    idle(6);
    check("satp_count", q_data.size(), 16);
    if (q_data.size() >= 16) begin
      check("satp_first", q_data[0], 32766);
      check("satp_first_sat", q_sat[0], 0);
      check("satp_last", q_data[15], 65535);
      check("satp_last_sat", q_sat[15], 1);
    end
    flush_pl();
    clear_q();
    repeat (16) send(-32768);
    idle(6);
    check("satn_count", q_data.size(), 16);
    if (q_data.size() >= 16) begin
      check("satn_first", q_data[0], -32767);
      check("satn_first_sat", q_sat[0], 0);
      check("satn_last", q_data[15], -65536);
      check("satn_last_sat", q_sat[15], 1);
    end

    // valid gaps must not change results
    load_bank(c_imp);
    flush_pl();
    clear_q();
    for (int i = 0; i < 20; i++) send(seq[i]);
    idle(6);
    check("gap_ref_count", q_data.size(), 20);
    if (q_data.size() > 0) check("gap_ref_first", q_data[0], 3);
    ref_a = q_data;
    flush_pl();
    clear_q();
    for (int i = 0; i < 20; i++) begin
      idle(int'($urandom_range(0, 3)));
      send(seq[i]);
    end
    idle(6);
    check("gap_count", q_data.size(), 20);
    for (int i = 0; i < q_data.size() && i < ref_a.size(); i++)
      check($sformatf("gap_%0d", i), q_data[i], ref_a[i]);

    // coefficient update timing
    flush_pl();
    load_bank(c_rnd);
    clear_q();
    send(1000);
    wr(0, 8192);
    send(1000);
    send(1000);
    drive(1'b1, 1000, 1'b0, 0, 0, 1'b1, 1'b0);
    send(1000);
    drive(1'b0, 0, 1'b1, 0, 4096, 1'b1, 1'b0);
    send(1000);
    commit();
    send(1000);
    idle(6);
    check("cu_count", q_data.size(), 7);
    for (int i = 0; i < q_data.size() && i < 7; i++)
      check($sformatf("cu_%0d", i), q_data[i], exp_cu[i]);

    // flush with a sample in the same cycle
    load_bank(c_imp);
    flush_pl();
    clear_q();
    send(32767);
    send(32767);
    drive(1'b1, 32767, 1'b0, 0, 0, 1'b0, 1'b1);
    send(1000);
    idle(6);
    check("flush_count", q_data.size(), 1);
    if (q_data.size() > 0) check("flush_after", q_data[0], 31);

    // asynchronous reset mid-stream
    load_bank(c_rnd);
    flush_pl();
    repeat (4) send(32767);
    check("rst_pre_valid", bus.out_valid, 1);
    check("rst_pre_data", bus.out_data, 16384);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sd32767;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_sat", bus.out_sat, 0);
    bus.in_valid = 1'b0;
    clear_q();
    @(negedge clk);
    rst_n = 1'b1;
    idle(8);
    check("rst_no_stale", q_data.size(), 0);
    check("rst_data_hold", bus.out_data, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fir_eq_filter.md
# fir_eq_filter

Parametrised, streaming FIR filter for the equalizer datapath, sitting between the sample front-end and the decision/slicer stage. It accepts one signed sample per valid cycle and keeps a TAPS-deep delay line that advances only on accepted samples. It produces a rounded, saturated output with a fixed pipeline latency. Coefficients are run-time programmable through a double-buffered bank, so they can be updated without glitching the output stream.

## Interface
- DATA_W, 16, input sample width (signed)
- COEF_W, 16, coefficient width (signed, Q1.(COEF_W-1))
- TAPS, 16, number of taps (≥2)
- OUT_W, 17, output width (signed)
- FRAC, COEF_W-1, right-shift applied after accumulation
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  in_data valid this cycle
- in_data  in  DATA_W  input sample
- flush  in  1  synchronous clear of delay line and in-flight samples
- coef_we  in  1  write coef_wdata to shadow[coef_addr]
- coef_addr  in  $clog2(TAPS)  shadow bank index
- coef_wdata  in  COEF_W  coefficient value
- coef_commit  in  1  copy the whole shadow bank to the active bank
- out_valid  out  1  out_data valid
- out_data  out  OUT_W  filtered sample
- out_sat  out  1  out_data was clipped (aligned with out_valid)

## Operation
- Delay line: on an edge with in_valid=1, tap[0]←in_data and tap[i]←tap[i-1]. No shift when in_valid=0, so gaps in the input do not change results.
- Arithmetic: each product is tap[i]*active[i], full precision. Products are summed in ACC_W = DATA_W+COEF_W+$clog2(TAPS) bits, so the sum cannot overflow.
- Rounding: add 2^(FRAC-1), then arithmetic-shift right by FRAC. This is round-half-up.
- Saturation: clip to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. out_sat=1 when clipping occurs.
- Coefficient banks: a coef_we write touches only the shadow bank. coef_commit copies the full shadow bank to the active bank in one edge.
  - If coef_we and coef_commit are asserted in the same cycle, the commit copies the shadow contents as they were before the write. The write lands in the shadow bank only.
- Which bank a sample uses: a sample accepted at edge k uses the active bank as updated by commits at edges ≤k.
- Flush:
  - Zeroes all taps and clears every in-flight valid bit on the same edge.
  - Leaves both coefficient banks unchanged.
  - flush with in_valid in the same cycle: flush wins and the sample is dropped.
- Reset: all taps, pipeline registers and both coefficient banks go to 0. out_valid=0, out_data=0, out_sat=0.
- Reset asserted mid-stream: all in-flight samples are discarded. No out_valid pulse follows release.

## Timing
- Pipeline stages:
  - Edge k: sample accepted into tap[0].
  - Edge k+1: products registered.
  - Edge k+2: sum registered.
  - Edge k+3: round/saturate registered to the outputs.
- Latency: fixed at 3 cycles from the accept edge to out_valid=1.
- Throughput: one sample per cycle.
- out_valid is a one-cycle pulse per accepted sample. It is a pure delayed copy of the accepted-valid signal.
- out_data and out_sat hold their last value while out_valid=0.
- There is no backpressure. The downstream stage must accept every out_valid pulse.

## Structure
- Package fir_eq_pkg holds:
  - default width constants;
  - the ACC_W derivation;
  - the round_sat function (value, FRAC, OUT_W) → {sat, result}.
- Sub-module fir_coef_bank holds the shadow and active register arrays, the write port and the commit logic. It exposes the active bank as a flat TAPS×COEF_W vector.
- The top level contains the delay line, the valid shift register and the three-stage datapath.

## Test plan
- Impulse response:
  - Stimulus: commit coef[i]=1000*(i+1), then send sample 32767 followed by 15 zeros.
  - Required response: outputs are round(32767*coef[i]/32768); the first output is 1000. Latency is exactly 3 cycles.
- Rounding:
  - Stimulus: coef[0]=16384, all other coefficients 0; input 32767.
  - Required response: out=16384 (16383.5 rounds up); input -32767 gives -16383.
- Saturation, positive and negative:
  - Stimulus: all coefficients 32767; 16 samples of 32767.
  - Required response: out=65535 with out_sat=1.
  - Same coefficients with input -32768 → out=-65536, out_sat=1.
- Valid gaps:
  - Stimulus: the same 20-sample sequence sent back-to-back, then with random in_valid gaps.
  - Required response: identical out_data sequences, and the out_valid count equals the accept count.
- Coefficient update:
  - Stimulus: rewrite the shadow bank mid-stream without committing.
  - Required response: outputs are unchanged.
  - Commit at edge k: the sample accepted at edge k and all later samples use the new bank; the sample at edge k-1 uses the old bank.
  - coef_we together with coef_commit: the new write is not active until the next commit.
- Flush and reset:
  - Stimulus: flush with in_valid high mid-stream.
  - Required response: no out_valid for in-flight samples or for the dropped sample; the next output uses zeroed taps.
  - rst_n pulsed mid-stream: all outputs go to 0 immediately, and no stale out_valid appears after release.
